// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: steers a stream of weight words into a bank of NUM_PE
// SIMD weight registers, one tile at a time. Each loaded bank goes to the
// compute engine, and the next tile starts loading once compute acknowledges.
module weight_load_ctrl #(
   parameter  int NUM_PE        = 4,
   parameter  int WEIGHT_LEVELS = 2,
   parameter  int SIMD_WIDTH    = 32,
   parameter  int TILE_W        = 16,
   localparam int DW            = SIMD_WIDTH * WEIGHT_LEVELS,
   localparam int PW            = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [TILE_W-1:0] num_tiles,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_data,
   output logic [DW-1:0]     reg_data,
   output logic [NUM_PE-1:0] reg_en,
   output logic              compute_valid,
   input  logic              compute_ack,
   output logic [TILE_W-1:0] tile_idx,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      FIN     = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     pe_idx_q, pe_idx_d;
   logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
   logic [TILE_W-1:0] tiles_q, tiles_d;

   logic xfer;
   logic last_pe;
   logic last_tile;

   assign xfer      = (state_q == LOAD) && in_valid;
   assign last_pe   = (pe_idx_q == PW'(NUM_PE - 1));
   assign last_tile = (tile_idx_q == (tiles_q - TILE_W'(1)));

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pe_idx_q   <= '0;
         tile_idx_q <= '0;
         tiles_q    <= '0;
      end else begin
         state_q    <= state_d;
         pe_idx_q   <= pe_idx_d;
         tile_idx_q <= tile_idx_d;
         tiles_q    <= tiles_d;
      end
   end

   // Next-state logic; abort overrides every other transition
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start) state_d = (num_tiles == '0) ? FIN : LOAD;
            LOAD:    if (xfer && last_pe) state_d = COMPUTE;
            COMPUTE: if (compute_ack) state_d = last_tile ? FIN : LOAD;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Counter updates: register index, tile index, latched tile count
   always_comb begin
      pe_idx_d   = pe_idx_q;
      tile_idx_d = tile_idx_q;
      tiles_d    = tiles_q;
      if (abort) begin
         pe_idx_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  tiles_d    = num_tiles;
                  tile_idx_d = '0;
                  pe_idx_d   = '0;
               end
            end
            LOAD: begin
               if (xfer) pe_idx_d = last_pe ? '0 : pe_idx_q + PW'(1);
            end
            COMPUTE: begin
               if (compute_ack && !last_tile) tile_idx_d = tile_idx_q + TILE_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Output decode from registered state (reg_en also qualified by in_valid)
   always_comb begin
      in_ready      = (state_q == LOAD);
      compute_valid = (state_q == COMPUTE);
      busy          = (state_q != IDLE);
      done          = (state_q == FIN);
      reg_en        = '0;
      if (xfer) reg_en = NUM_PE'(1) << pe_idx_q;
   end

   assign reg_data = in_data;
   assign tile_idx = tile_idx_q;

endmodule

// File: doc/weight_load_ctrl.md
# weight_load_ctrl

Sequencer for a bank of `NUM_PE` SIMD weight registers (each `SIMD_WIDTH*WEIGHT_LEVELS` bits, synchronous load-enable) feeding the binarized compute array. For each weight tile, it accepts a stream of weight words over a valid/ready handshake and steers each word to the next register with a one-hot enable. It then hands the loaded bank to the compute engine and waits for its acknowledge before loading the next tile, repeating for a programmed tile count.

## Interface
- `NUM_PE`, 4: number of weight registers in the bank; must be ≥ 1.
- `WEIGHT_LEVELS`, 2: residual binarization levels per weight.
- `SIMD_WIDTH`, 32: weights per register.
- `TILE_W`, 16: width of the tile counter.
- Local `DW = SIMD_WIDTH*WEIGHT_LEVELS`; local `PW = max(1, clog2(NUM_PE))`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a job; honoured only in IDLE.
- `abort`  in  1  synchronous abort; returns the block to IDLE from any state.
- `num_tiles`  in  TILE_W  tile count, sampled on an accepted `start`.
- `in_valid`  in  1  weight word valid.
- `in_ready`  out  1  block accepts a weight word.
- `in_data`  in  DW  weight word.
- `reg_data`  out  DW  broadcast data to all registers; equals `in_data`, combinational.
- `reg_en`  out  NUM_PE  one-hot load enable; bit `pe_idx` is high only on an accepted word.
- `compute_valid`  out  1  bank is loaded and the tile is ready for compute.
- `compute_ack`  in  1  compute engine has consumed the bank.
- `tile_idx`  out  TILE_W  index of the current tile.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at normal job completion.

## Operation
States are IDLE, LOAD, COMPUTE and FIN.

- **IDLE:**
  - `start` latches `num_tiles` into `tiles_r` and clears `tile_idx` and `pe_idx`.
  - If `num_tiles == 0`, go to FIN; otherwise go to LOAD.
- **LOAD:**
  - `in_ready = 1`.
  - A transfer occurs when `in_valid & in_ready`. On that cycle `reg_en = 1 << pe_idx` (combinational), so register `pe_idx` captures `in_data` at the same edge.
  - `pe_idx` increments on each transfer.
  - A transfer with `pe_idx == NUM_PE-1` wraps `pe_idx` to 0 and moves to COMPUTE.
  - No transfer means no enable and no state change. Bubbles of any length are legal.
- **COMPUTE:**
  - `compute_valid = 1`, held until `compute_ack`; `in_ready = 0`.
  - `compute_ack` with `tile_idx == tiles_r-1` goes to FIN.
  - Otherwise `compute_ack` increments `tile_idx` and returns to LOAD.
  - `compute_ack` outside COMPUTE is ignored.
- **FIN:**
  - `done = 1` for exactly one cycle, then go to IDLE.
  - `tile_idx` holds its last value until the next `start`.
- **`abort`:**
  - Has priority over all other transitions in every state.
  - Next state is IDLE, `pe_idx` becomes 0, and `done` is not pulsed.
  - Registers already loaded are left as they are; the block does not clear them.
- **`start` while `busy`:** ignored; `num_tiles` is not resampled.
- **Output decode:** all of `in_ready`, `reg_en`, `compute_valid`, `busy` and `done` are decoded from state and are glitch-free relative to `clk`. `reg_en` additionally depends on `in_valid` in LOAD.
- **Arithmetic:** counters are unsigned and do not saturate. `tile_idx` never exceeds `tiles_r-1`. A `num_tiles` value of `2^TILE_W - 1` is legal.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - State becomes IDLE; `pe_idx = 0`, `tile_idx = 0`, `tiles_r = 0`.
  - `in_ready`, `reg_en`, `compute_valid`, `busy` and `done` are all 0.
  - Deassertion is synchronised externally.
  - Reset mid-transfer drops the word.
- **`start` to first `in_ready`:** 1 cycle. `start` is sampled at edge N and `in_ready` is high during cycle N+1.
- **Last word to `compute_valid`:** the last transfer at edge N puts `compute_valid` high in cycle N+1. The last register holds its data from edge N.
- **`compute_ack` to next `in_ready`:** `compute_ack` at edge N puts `in_ready` high in cycle N+1.
- **Final `compute_ack` to `done`:** the final ack at edge N gives `done` in cycle N+1 and `busy` low from cycle N+2.
- **Minimum job length:** `tiles*(NUM_PE+1) + 2` cycles with back-to-back data and immediate ack.

## Test plan
- **Basic job:** `NUM_PE=4`, `num_tiles=2`, continuous `in_valid` with words `0xA0..0xA7`, ack 3 cycles after each `compute_valid`.
  - `reg_en` sequence 1,2,4,8,1,2,4,8 carrying those words.
  - `compute_valid` twice, `tile_idx` 0 then 1.
  - One `done` pulse; `busy` low afterwards.
- **Back-pressure:** `in_valid` toggles 1,0,0,1,… within a tile.
  - `reg_en` fires only on valid cycles; `pe_idx` holds across bubbles.
  - Exactly 4 enables per tile.
- **Zero tiles:** `start` with `num_tiles=0`.
  - `busy` for 1 cycle, `done` in cycle N+1.
  - No `in_ready` and no `reg_en`.
- **Abort mid-load:**
  - Abort after 2 transfers: no `done`, IDLE next cycle.
  - A new `start` with `num_tiles=1` then loads starting at `reg_en=1`.
- **Abort in COMPUTE:** `compute_valid` drops next cycle and `done` never asserts.
- **Ignored inputs and reset:**
  - `start` pulsed during LOAD and `compute_ack` pulsed during LOAD have no effect.
  - `rst_n` asserted mid-COMPUTE asynchronously zeroes all outputs within the same cycle.
